alu_result_stage: RTL and testbench

//  Execute/writeback boundary stage placed directly after the CR16 ALU.
//  - Captures the ALU result, its 5-bit status, and writeback control into a 2-entry in-order buffer with a valid/ready handshake.
//  - Maintains the architectural processor status register (PSR) with per-instruction flag-update masks.
//  - Lets the ALU stay purely combinational while the register-file writeback path stalls.

---
 rtl/alu_result_stage.sv | 95 +++++++++
 tb/tb_alu_result_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Execute/writeback boundary stage: a 2-entry in-order result buffer with a
// valid/ready handshake and the architectural PSR updated under per-op masks.
module alu_result_stage #(
  parameter int P_WIDTH      = 16,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    I_CLK,
  input  logic                    I_NRESET,
  input  logic                    I_VALID,
  output logic                    O_READY,
  input  logic [P_WIDTH-1:0]      I_C,
  input  logic [4:0]              I_STATUS,
  input  logic [4:0]              I_STATUS_MASK,
  input  logic                    I_WRITE_RESULT,
  input  logic [P_ADDR_WIDTH-1:0] I_DEST_ADDR,
  input  logic                    I_FLUSH,
  output logic                    O_VALID,
  input  logic                    I_READY,
  output logic [P_WIDTH-1:0]      O_RESULT,
  output logic [P_ADDR_WIDTH-1:0] O_DEST_ADDR,
  output logic                    O_WRITE_RESULT,
  output logic [4:0]              O_PSR
);

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high and I_FLUSH is low; ready never looks at the downstream ready, and
  // the head entry holds steady while O_VALID & ~I_READY.

  localparam int ENTRY_W = P_WIDTH + P_ADDR_WIDTH + 1;

  logic [1:0]         count;
  logic [ENTRY_W-1:0] entry_head;
  logic [ENTRY_W-1:0] entry_tail;
  logic [ENTRY_W-1:0] entry_in;
  logic               push;
  logic               pop;
  logic [4:0]         psr;

  assign entry_in = {I_WRITE_RESULT, I_DEST_ADDR, I_C};

  assign O_READY = I_NRESET & (count != 2'd2);
  assign O_VALID = (count != 2'd0);
  assign push    = I_VALID & O_READY & ~I_FLUSH;
  assign pop     = O_VALID & I_READY & ~I_FLUSH;

  assign O_RESULT       = entry_head[P_WIDTH-1:0];
  assign O_DEST_ADDR    = entry_head[P_WIDTH +: P_ADDR_WIDTH];
  assign O_WRITE_RESULT = entry_head[ENTRY_W-1];
  assign O_PSR          = psr;

  // Head is always slot 0; the tail slot only holds data when count = 2.
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      count      <= 2'd0;
      entry_head <= '0;
      entry_tail <= '0;
    end else if (I_FLUSH) begin
      count      <= 2'd0;
      entry_head <= '0;
      entry_tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            entry_head <= entry_in;
          end else begin
            entry_tail <= entry_in;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          entry_head <= entry_tail;
          entry_tail <= '0;
          count      <= count - 2'd1;
        end
        2'b11: begin
          // Only reachable at count = 1: the new entry replaces the head.
          entry_head <= entry_in;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      psr <= 5'b00000;
    end else if (push) begin
      psr <= (psr & ~I_STATUS_MASK) | (I_STATUS & I_STATUS_MASK);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model compared every
// cycle, plus directed scenarios with literal expected values.
module tb_alu_result_stage;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int EW = W + AW + 1;

  logic          clk = 1'b0;
  logic          nreset;
  logic          valid_in;
  logic          ready_out;
  logic [W-1:0]  c_in;
  logic [4:0]    status_in;
  logic [4:0]    mask_in;
  logic          write_in;
  logic [AW-1:0] dest_in;
  logic          flush;
  logic          valid_out;
  logic          ready_in;
  logic [W-1:0]  result_out;
  logic [AW-1:0] dest_out;
  logic          write_out;
  logic [4:0]    psr_out;

  int compared   = 0;
  int mismatched = 0;

  logic [EW-1:0] exp_q[$];
  logic [4:0]    exp_psr;

  alu_result_stage #(.P_WIDTH(W), .P_ADDR_WIDTH(AW)) dut (
    .I_CLK(clk), .I_NRESET(nreset), .I_VALID(valid_in), .O_READY(ready_out),
    .I_C(c_in), .I_STATUS(status_in), .I_STATUS_MASK(mask_in),
    .I_WRITE_RESULT(write_in), .I_DEST_ADDR(dest_in), .I_FLUSH(flush),
    .O_VALID(valid_out), .I_READY(ready_in), .O_RESULT(result_out),
    .O_DEST_ADDR(dest_out), .O_WRITE_RESULT(write_out), .O_PSR(psr_out)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain FIFO of up to two entries and a masked PSR.
  always @(posedge clk) begin
    bit m_push;
    bit m_pop;
    if (!nreset) begin
      exp_q.delete();
      exp_psr = 5'b00000;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      m_push = valid_in && (exp_q.size() < 2);
      m_pop  = (exp_q.size() > 0) && ready_in;
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        exp_q.push_back({write_in, dest_in, c_in});
        exp_psr = (exp_psr & ~mask_in) | (status_in & mask_in);
      end
    end
  end

  // Scoreboard compare, every cycle on the falling edge.
  always @(negedge clk) begin
    check("ready", {31'd0, ready_out}, {31'd0, (nreset === 1'b1) && (exp_q.size() < 2)});
    check("valid", {31'd0, valid_out}, {31'd0, exp_q.size() != 0});
    check("psr", {27'd0, psr_out}, {27'd0, exp_psr});
    if (exp_q.size() != 0)
      check("head", {11'd0, write_out, dest_out, result_out}, {11'd0, exp_q[0]});
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] c, input logic [4:0] st,
                       input logic [4:0] mk, input logic wr, input logic [AW-1:0] d,
                       input logic rdy, input logic fl);
    valid_in  = v;
    c_in      = c;
    status_in = st;
    mask_in   = mk;
    write_in  = wr;
    dest_in   = d;
    ready_in  = rdy;
    flush     = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, '0, 5'b0, 5'b0, 1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    nreset = 1'b0;
    drive(1'b1, 16'hFFFF, 5'b11111, 5'b11111, 1'b1, 4'hF, 1'b1, 1'b0);

    // 1. reset held two cycles with valid asserted
    tick();
    tick();
    check("rst_ready", {31'd0, ready_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_psr", {27'd0, psr_out}, 32'd0);
    check("rst_result", {16'd0, result_out}, 32'd0);
    nreset = 1'b1;
    idle(1'b1);
    tick();

    // 2. single push, one-cycle latency, then drains
    drive(1'b1, 16'h1234, 5'b01000, 5'b11111, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    check("t2_valid", {31'd0, valid_out}, 32'd1);
    check("t2_result", {16'd0, result_out}, 32'h1234);
    check("t2_dest", {28'd0, dest_out}, 32'd3);
    check("t2_psr", {27'd0, psr_out}, 32'b01000);
    tick();
    check("t2_empty", {31'd0, valid_out}, 32'd0);

    // 3. backpressure: A, B accepted, C held then delivered in order
    drive(1'b1, 16'h0001, 5'b0, 5'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0002, 5'b0, 5'b0, 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0003, 5'b0, 5'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    check("t3_full", {31'd0, ready_out}, 32'd0);
    tick();
    check("t3_head_a", {16'd0, result_out}, 32'h0001);
    ready_in = 1'b1;
    tick();
    check("t3_head_b", {16'd0, result_out}, 32'h0002);
    tick();
    idle(1'b1);
    check("t3_head_c", {16'd0, result_out}, 32'h0003);
    tick();
    check("t3_drained", {31'd0, valid_out}, 32'd0);

    // 4. masked PSR updates
    drive(1'b1, 16'h0010, 5'b11111, 5'b11111, 1'b1, 4'd4, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0011, 5'b00000, 5'b01001, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    check("t4_psr_masked", {27'd0, psr_out}, 32'b10110);
    drive(1'b1, 16'h0012, 5'b11111, 5'b00000, 1'b0, 4'd6, 1'b1, 1'b0);
    tick();
    idle(1'b1);
    check("t4_psr_nomask", {27'd0, psr_out}, 32'b10110);
    check("t4_write0", {31'd0, write_out}, 32'd0);
    tick();

    // 5. flush at count 2 drops the same-cycle push and PSR update
    drive(1'b1, 16'h0020, 5'b0, 5'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0021, 5'b0, 5'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0022, 5'b11111, 5'b11111, 1'b1, 4'd9, 1'b1, 1'b1);
    tick();
    idle(1'b0);
    check("t5_valid", {31'd0, valid_out}, 32'd0);
    check("t5_ready", {31'd0, ready_out}, 32'd1);
    check("t5_psr", {27'd0, psr_out}, 32'b10110);

    // 6. push and pop together at count 1
    drive(1'b1, 16'h00AA, 5'b0, 5'b0, 1'b1, 4'd10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h00BB, 5'b0, 5'b0, 1'b1, 4'd11, 1'b1, 1'b0);
    tick();
    idle(1'b0);
    check("t6_valid", {31'd0, valid_out}, 32'd1);
    check("t6_result", {16'd0, result_out}, 32'h00BB);
    check("t6_ready", {31'd0, ready_out}, 32'd1);
    tick();

    // mixed traffic with toggling downstream ready
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
      tick();
    end

    // reset mid-burst
    drive(1'b1, 16'h0055, 5'b10101, 5'b11111, 1'b1, 4'd2, 1'b0, 1'b0);
    tick();
    tick();
    nreset = 1'b0;
    tick();
    check("rst2_ready", {31'd0, ready_out}, 32'd0);
    check("rst2_valid", {31'd0, valid_out}, 32'd0);
    check("rst2_psr", {27'd0, psr_out}, 32'd0);
    check("rst2_result", {16'd0, result_out}, 32'd0);
    check("rst2_dest", {28'd0, dest_out}, 32'd0);
    nreset = 1'b1;
    idle(1'b1);
    tick();
    tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
